// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencing controller: FSM state type,
// parameter defaults and the counter width helper.
package cordic_pkg;

    localparam int CORDIC_N_ITER_DEF  = 32;
    localparam int CORDIC_N_VAR_DEF   = 3;
    localparam int CORDIC_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IN = 3'd1,
        S_CHECK   = 3'd2,
        S_PREP    = 3'd3,
        S_ISSUE   = 3'd4,
        S_WAIT    = 3'd5,
        S_ADVANCE = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Index width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Handshake and datapath-strobe bundle between the CORDIC sequencer and its host.
interface cordic_seq_ctrl_if #(
    parameter int N_ITER = cordic_pkg::CORDIC_N_ITER_DEF,
    parameter int N_VAR  = cordic_pkg::CORDIC_N_VAR_DEF
);
    import cordic_pkg::*;

    localparam int VW = cnt_width(N_VAR);
    localparam int IW = cnt_width(N_ITER);

    logic          start, ack, mode, exception, addsub_done;
    logic          busy, ready, abort, mode_q;
    logic          reset_regs, load_in, load_quad, load_shift, begin_addsub, load_out;
    logic [VW-1:0] var_sel;
    logic [IW-1:0] iter_idx;

    modport master (
        output start, ack, mode, exception, addsub_done,
        input  busy, ready, abort, mode_q,
        input  reset_regs, load_in, load_quad, load_shift, begin_addsub, load_out,
        input  var_sel, iter_idx
    );

    modport slave (
        input  start, ack, mode, exception, addsub_done,
        output busy, ready, abort, mode_q,
        output reset_regs, load_in, load_quad, load_shift, begin_addsub, load_out,
        output var_sel, iter_idx
    );

endinterface

// File: rtl/cordic_cnt.sv
// Up-counter with synchronous clear and enable; saturates at MAX-1 and
// flags that terminal value on tick so indices never wrap mid-operation.
module cordic_cnt #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tick
);

    logic [W-1:0] cnt_r;
    logic         tick_s;

    assign tick_s = (cnt_r == W'(MAX - 1));

    // Count register: clear wins over enable, hold at terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !tick_s) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign tick = tick_s;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// CORDIC micro-rotation sequencer. Define CORDIC_SEQ_TIMEOUT_EN to add a
// watchdog that aborts an operation stuck in WAIT for TIMEOUT_CYC cycles.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER      = CORDIC_N_ITER_DEF,
    parameter int N_VAR       = CORDIC_N_VAR_DEF,
    parameter int TIMEOUT_CYC = CORDIC_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    cordic_seq_ctrl_if.slave bus
);

    localparam int VW = cnt_width(N_VAR);
    localparam int IW = cnt_width(N_ITER);

    state_t        state_r, state_s;
    logic          mode_r;
    logic [VW-1:0] var_cnt_s;
    logic [IW-1:0] iter_cnt_s;
    logic          var_tick_s, iter_tick_s;
    logic          busy_s, ready_s, abort_s, reset_regs_s, load_in_s;
    logic          load_quad_s, load_shift_s, begin_addsub_s, load_out_s;

    // Counters clear on the transition that leaves their live range, so the
    // indices read 0 in every state that does not use them.
    cordic_cnt #(.MAX(N_VAR), .W(VW)) u_var_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_s != S_ISSUE) && (state_s != S_WAIT)),
        .en    (state_r == S_ISSUE),
        .cnt   (var_cnt_s),
        .tick  (var_tick_s)
    );

    cordic_cnt #(.MAX(N_ITER), .W(IW)) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_s == S_IDLE),
        .en    (state_r == S_ADVANCE),
        .cnt   (iter_cnt_s),
        .tick  (iter_tick_s)
    );

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam int WW = cnt_width(TIMEOUT_CYC);
    logic [WW-1:0] wdog_cnt_s;
    logic          wdog_tick_s;

    cordic_cnt #(.MAX(TIMEOUT_CYC), .W(WW)) u_wdog_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_s != S_WAIT),
        .en    (state_r == S_WAIT),
        .cnt   (wdog_cnt_s),
        .tick  (wdog_tick_s)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operating mode captured only when an operation is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r <= 1'b0;
        end else if ((state_r == S_IDLE) && bus.start) begin
            mode_r <= bus.mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_s        = state_r;
        busy_s         = 1'b1;
        ready_s        = 1'b0;
        abort_s        = 1'b0;
        reset_regs_s   = 1'b0;
        load_in_s      = 1'b0;
        load_quad_s    = 1'b0;
        load_shift_s   = 1'b0;
        begin_addsub_s = 1'b0;
        load_out_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_s       = 1'b0;
                reset_regs_s = 1'b1;
                if (bus.start) state_s = S_LOAD_IN;
                else           state_s = S_IDLE;
            end
            S_LOAD_IN: begin
                load_in_s = 1'b1;
                state_s   = S_CHECK;
            end
            S_CHECK: begin
                load_quad_s = 1'b1;
                if (bus.exception) begin
                    abort_s = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_PREP;
                end
            end
            S_PREP: begin
                load_shift_s = 1'b1;
                state_s      = S_ISSUE;
            end
            S_ISSUE: begin
                begin_addsub_s = 1'b1;
                if (var_tick_s) state_s = S_WAIT;
                else            state_s = S_ISSUE;
            end
            S_WAIT: begin
                begin_addsub_s = 1'b1;
                if (bus.addsub_done) begin
                    state_s = S_ADVANCE;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                end else if (wdog_tick_s) begin
                    abort_s = 1'b1;
                    state_s = S_IDLE;
`endif
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_ADVANCE: begin
                if (iter_tick_s) begin
                    load_out_s = 1'b1;
                    state_s    = S_DONE;
                end else begin
                    state_s    = S_CHECK;
                end
            end
            S_DONE: begin
                busy_s     = 1'b0;
                ready_s    = 1'b1;
                load_out_s = 1'b1;
                if (bus.ack) state_s = S_IDLE;
                else         state_s = S_DONE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    assign bus.busy         = busy_s;
    assign bus.ready        = ready_s;
    assign bus.abort        = abort_s;
    assign bus.mode_q       = mode_r;
    assign bus.reset_regs   = reset_regs_s;
    assign bus.load_in      = load_in_s;
    assign bus.load_quad    = load_quad_s;
    assign bus.load_shift   = load_shift_s;
    assign bus.begin_addsub = begin_addsub_s;
    assign bus.load_out     = load_out_s;
    assign bus.var_sel      = var_cnt_s;
    assign bus.iter_idx     = iter_cnt_s;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: randomized operations checked cycle by cycle
// against an expected output trace built from the sequencing rules.
module tb_cordic_seq_ctrl;
    import cordic_pkg::*;

    localparam int NI = 4;
    localparam int NV = 3;
    localparam int TO = 8;
    localparam int VW = (NV < 2) ? 1 : $clog2(NV);
    localparam int IW = (NI < 2) ? 1 : $clog2(NI);
    localparam int OW = 10 + VW + IW;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_PREP  = 3;
    localparam int PH_ISSUE = 4;
    localparam int PH_WAIT  = 5;
    localparam int PH_ADV   = 6;
    localparam int PH_DONE  = 7;

    typedef struct packed {
        logic busy, ready, abort, rr, li, lq, ls, ba, lo, mq;
        logic [VW-1:0] vs;
        logic [IW-1:0] it;
    } ov_t;
    typedef logic [OW-1:0] ov_vec_t;

    logic    clk;
    logic    reset;
    int      n_cmp;
    int      n_err;
    logic    mq_m;
    ov_vec_t obs;

    cordic_seq_ctrl_if #(.N_ITER(NI), .N_VAR(NV)) bus ();

    cordic_seq_ctrl #(.N_ITER(NI), .N_VAR(NV), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.busy, bus.ready, bus.abort, bus.reset_regs, bus.load_in,
                  bus.load_quad, bus.load_shift, bus.begin_addsub, bus.load_out,
                  bus.mode_q, bus.var_sel, bus.iter_idx};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    // Expected outputs for one cycle in a given phase of an operation.
    function automatic ov_vec_t ex(input int ph, input int vs, input int it, input bit flag);
        ov_t o;
        o    = '0;
        o.mq = mq_m;
        o.vs = VW'(vs);
        o.it = IW'(it);
        case (ph)
            PH_IDLE:  o.rr = 1'b1;
            PH_LOAD:  o.li = 1'b1;
            PH_CHECK: begin o.lq = 1'b1; o.abort = flag; end
            PH_PREP:  o.ls = 1'b1;
            PH_ISSUE: o.ba = 1'b1;
            PH_WAIT:  begin o.ba = 1'b1; o.abort = flag; end
            PH_ADV:   o.lo = flag;
            PH_DONE:  begin o.ready = 1'b1; o.lo = 1'b1; end
            default:  o = '0;
        endcase
        o.busy = (ph != PH_IDLE) && (ph != PH_DONE);
        return o;
    endfunction

    task automatic chk(input ov_vec_t exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic m, input logic e,
                       input logic d, input ov_vec_t exp, input string tag);
        @(negedge clk);
        bus.start = s; bus.ack = a; bus.mode = m; bus.exception = e; bus.addsub_done = d;
        #1;
        chk(exp, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.start = 1'b0; bus.ack = 1'b0; bus.exception = 1'b0; bus.addsub_done = 1'b1;
        reset = 1'b1;
        #1;
        mq_m = 1'b0;
        chk(ex(PH_IDLE, 0, 0, 1'b0), tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One operation: optional exception at CHECK of exc_it, reset during
    // ISSUE of rst_it, or a WAIT that never sees addsub_done (hang).
    task automatic run_op(input logic m, input int exc_it, input int rst_it,
                          input bit hang, input int ack_dly);
        int w;
        cyc(1'b1, 1'b0, m, 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0), "idle_start");
        mq_m = m;
        cyc(1'($urandom), 1'b0, ~m, 1'b0, 1'b1, ex(PH_LOAD, 0, 0, 1'b0), "load_in");
        for (int it = 0; it < NI; it++) begin
            if (it == exc_it) begin
                cyc(1'b0, 1'b0, 1'($urandom), 1'b1, 1'b1, ex(PH_CHECK, 0, it, 1'b1), "check_abort");
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0), "idle_after_abort");
                return;
            end
            cyc(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom), ex(PH_CHECK, 0, it, 1'b0), "check");
            cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), ex(PH_PREP, 0, it, 1'b0), "prep");
            for (int v = 0; v < NV; v++) begin
                if ((it == rst_it) && (v == 1)) begin
                    do_reset("reset_mid_issue");
                    return;
                end
                cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                    ex(PH_ISSUE, v, it, 1'b0), "issue");
            end
            if (hang) begin
`ifdef CORDIC_SEQ_TIMEOUT_EN
                for (int k = 1; k <= TO; k++)
                    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(PH_WAIT, NV - 1, it, k == TO), "wdog_wait");
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0), "idle_after_timeout");
`else
                for (int k = 1; k <= 3 * TO; k++)
                    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(PH_WAIT, NV - 1, it, 1'b0), "wait_forever");
                do_reset("reset_from_wait");
`endif
                return;
            end
            w = $urandom_range(1, 3);
            for (int k = 1; k <= w; k++)
                cyc(1'($urandom), 1'b0, 1'($urandom), 1'b0, (k == w), ex(PH_WAIT, NV - 1, it, 1'b0), "wait");
            cyc(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom),
                ex(PH_ADV, 0, it, it == NI - 1), "advance");
        end
        for (int k = 0; k < ack_dly; k++)
            cyc(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b1, ex(PH_DONE, 0, NI - 1, 1'b0), "done_hold");
        cyc(1'b1, 1'b1, ~m, 1'b0, 1'b1, ex(PH_DONE, 0, NI - 1, 1'b0), "done_ack");
        cyc(1'b0, 1'b0, ~m, 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0), "idle_after_ack");
        cyc(1'b0, 1'b0, ~m, 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0), "idle_no_restart");
    endtask

    initial begin
        int  lat;
        int  prev;
        bit  got;
        bit  seq_ok;
        int  seq[$];

        n_cmp = 0; n_err = 0; mq_m = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.ack = 1'b0; bus.mode = 1'b0;
        bus.exception = 1'b0; bus.addsub_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk(ex(PH_IDLE, 0, 0, 1'b0), "reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Start-to-ready latency and issue order with addsub_done held high.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.addsub_done = 1'b1;
        lat = 0; prev = -1; got = 1'b0;
        for (int k = 1; (k <= 100) && !got; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.begin_addsub && (int'(bus.var_sel) != prev)) seq.push_back(int'(bus.var_sel));
            prev = bus.begin_addsub ? int'(bus.var_sel) : -1;
            if (bus.ready) begin
                got = 1'b1;
                lat = k;
            end
        end
        n_cmp++;
        assert (lat === 1 + NI * (NV + 4) + 1) else begin
            n_err++;
            $error("FAIL latency: observed %0d expected %0d", lat, 1 + NI * (NV + 4) + 1);
        end
        seq_ok = (seq.size() == NI * NV);
        foreach (seq[i]) if (seq[i] != (i % NV)) seq_ok = 1'b0;
        n_cmp++;
        assert (seq_ok === 1'b1) else begin
            n_err++;
            $error("FAIL var_sel_order: observed %0d entries ok=%0b expected %0d entries ok=1",
                   seq.size(), seq_ok, NI * NV);
        end
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        #1;
        chk(ex(PH_IDLE, 0, 0, 1'b0), "idle_after_latency");

        run_op(1'b1, -1, -1, 1'b0, 2);
        run_op(1'b0, -1, -1, 1'b0, 0);
        run_op(1'b1,  0, -1, 1'b0, 0);
        run_op(1'b0, -1, -1, 1'b0, 10);
        run_op(1'b1, -1,  1, 1'b0, 0);
        run_op(1'b0, -1, -1, 1'b1, 0);
        for (int r = 0; r < 8; r++)
            run_op(1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NI - 1)) : -1,
                   -1, 1'b0, int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
